// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM state type and special-case results for muldiv_unit.
package muldiv_pkg;
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  localparam logic [63:0] DIVZ_QUO = '1;
  localparam logic [63:0] OVF_REM  = '0;
endpackage

// File: rtl/muldiv_div_step.sv
// muldiv_div_step: one restoring-divide iteration (shift in dividend bit, trial subtract).
module muldiv_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic            i_bit,
  input  logic [XLEN-1:0] i_div,
  output logic [XLEN-1:0] o_rem,
  output logic            o_q
);
  import muldiv_pkg::*;
  logic [XLEN:0]   w_sh;
  logic [XLEN-1:0] w_diff;
  assign w_sh   = {i_rem, i_bit};
  assign w_diff = w_sh[XLEN-1:0] - i_div;
  assign o_q    = w_sh >= {1'b0, i_div};
  assign o_rem  = o_q ? w_diff : w_sh[XLEN-1:0];
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV M-extension multiply/divide with valid/ready handshake.
// Define MULDIV_FAST_MUL_EN for a single-cycle wide multiplier (divide stays iterative).
module muldiv_unit #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_w,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_res,
  output logic [TAG_W-1:0] out_tag
);
  import muldiv_pkg::*;
  localparam int CW = $clog2(XLEN + 1);
  state_t            r_state;
  logic [XLEN-1:0]   r_rem, r_quo, r_b, r_res;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic              r_w, r_neg, r_skip, r_hi;
  logic [TAG_W-1:0]  r_tag;
  logic              w_w, w_mulw, w_s1, w_s2, w_n1, w_n2, w_zero, w_ovf, w_spec, w_ld_skip, w_dq, w_inc;
  logic signed [31:0] w_lo1, w_lo2, w_vlo;
  logic [XLEN-1:0]   w_x1, w_x2, w_m1, w_m2, w_min, w_spec_res, w_ld_rem, w_ld_quo, w_ld_b;
  logic [XLEN-1:0]   w_drem, w_rn, w_qn, w_sel, w_v, w_fin;
  logic [XLEN:0]     w_sum;
  assign w_w    = in_w && (XLEN == 64);
  assign w_mulw = w_w && !in_op[2];
  assign w_s1   = !w_mulw && (in_op == OP_MULH || in_op == OP_MULHSU || in_op == OP_DIV || in_op == OP_REM);
  assign w_s2   = !w_mulw && (in_op == OP_MULH || in_op == OP_DIV || in_op == OP_REM);
  assign w_lo1  = in_src1[31:0];
  assign w_lo2  = in_src2[31:0];
  assign w_x1   = !w_w ? in_src1 : w_s1 ? XLEN'(w_lo1) : XLEN'(in_src1[31:0]);
  assign w_x2   = !w_w ? in_src2 : w_s2 ? XLEN'(w_lo2) : XLEN'(in_src2[31:0]);
  assign w_n1   = w_s1 & w_x1[XLEN-1];
  assign w_n2   = w_s2 & w_x2[XLEN-1];
  assign w_m1   = w_n1 ? -w_x1 : w_x1;
  assign w_m2   = w_n2 ? -w_x2 : w_x2;
  // Most negative value at the op's width, already sign-extended to XLEN
  assign w_min  = w_w ? {XLEN{1'b1}} << 31 : {XLEN{1'b1}} << (XLEN - 1);
  assign w_zero = w_x2 == '0;
  assign w_ovf  = w_s2 && w_x1 == w_min && w_x2 == '1;
  assign w_spec = in_op[2] && (w_zero || w_ovf);
  assign w_spec_res = w_zero ? (in_op[1] ? (w_w ? XLEN'(w_lo1) : in_src1) : XLEN'(DIVZ_QUO))
                             : (in_op[1] ? XLEN'(OVF_REM) : w_min);
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_prod;
  assign w_prod = ((2*XLEN)'(w_m1) * (2*XLEN)'(w_m2)) << (w_w ? 32 : 0);
`endif
  // W divides pre-shift the dividend so 32 iterations consume exactly its bits
  always_comb begin
    w_ld_skip = w_spec;
    w_ld_rem  = w_spec ? w_spec_res : '0;
    w_ld_quo  = !in_op[2] ? w_m2 : w_w ? w_m1 << (XLEN - 32) : w_m1;
    w_ld_b    = in_op[2] ? w_m2 : w_m1;
`ifdef MULDIV_FAST_MUL_EN
    if (!in_op[2]) begin
      w_ld_skip = 1'b1;
      {w_ld_rem, w_ld_quo} = w_prod;
    end
`endif
  end
  muldiv_div_step #(.XLEN(XLEN)) u_step (
    .i_rem(r_rem), .i_bit(r_quo[XLEN-1]), .i_div(r_b), .o_rem(w_drem), .o_q(w_dq)
  );
  assign w_sum = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_b} : '0);
  assign w_rn  = r_skip ? r_rem : r_op[2] ? w_drem : w_sum[XLEN:1];
  assign w_qn  = r_skip ? r_quo : r_op[2] ? {r_quo[XLEN-2:0], w_dq} : {w_sum[0], r_quo[XLEN-1:1]};
  assign w_sel = r_op[2] ? (r_op[1] ? w_rn : w_qn) : r_hi ? w_rn : r_w ? w_qn >> (XLEN - 32) : w_qn;
  // Negating a 2*XLEN product: high half carries in only when the low half is zero
  assign w_inc = (!r_op[2] && r_hi) ? (w_qn == '0) : 1'b1;
  assign w_v   = r_neg ? ~w_sel + XLEN'(w_inc) : w_sel;
  assign w_vlo = w_v[31:0];
  assign w_fin = (r_skip && r_op[2]) ? r_rem : r_w ? XLEN'(w_vlo) : w_v;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_res   <= '0;
      r_tag   <= '0;
      r_cnt   <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else if (r_state == S_IDLE) begin
      if (in_valid) begin
        r_state <= S_BUSY;
        r_op    <= in_op;
        r_w     <= w_w;
        r_tag   <= in_tag;
        r_rem   <= w_ld_rem;
        r_quo   <= w_ld_quo;
        r_b     <= w_ld_b;
        r_skip  <= w_ld_skip;
        r_neg   <= (in_op[2] && in_op[1]) ? w_n1 : w_n1 ^ w_n2;
        r_hi    <= !in_op[2] && in_op[1:0] != 2'd0 && !w_w;
        r_cnt   <= w_ld_skip ? CW'(1) : w_w ? CW'(32) : CW'(XLEN);
      end
    end else if (r_state == S_BUSY) begin
      r_rem <= w_rn;
      r_quo <= w_qn;
      r_cnt <= r_cnt - CW'(1);
      if (r_skip || r_cnt == CW'(1)) begin
        r_res   <= w_fin;
        r_state <= S_DONE;
      end
    end else if (out_ready) begin
      r_state <= S_IDLE;
    end
  end
  assign in_ready  = r_state == S_IDLE;
  assign out_valid = r_state == S_DONE;
  assign out_res   = r_res;
  assign out_tag   = r_tag;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic model.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_w, out_ready, in_ready, out_valid;
  logic [2:0]  in_op;
  logic [63:0] in_src1, in_src2, out_res;
  logic [4:0]  in_tag, out_tag;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(64), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_w(in_w), .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_tag(out_tag)
  );

  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sp;
    logic [127:0] up;
    longint sa, sb;
    int s32a, s32b;
    int unsigned ua, ub;
    logic [31:0] r;
    sa = a; sb = b; s32a = a[31:0]; s32b = b[31:0]; ua = a[31:0]; ub = b[31:0];
    if (w) begin
      if (op < 3'd4) r = ua * ub;
      else if (ub == 0) r = op[1] ? ua : 32'hFFFF_FFFF;
      else if (!op[0] && ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) r = op[1] ? 32'h0 : 32'h8000_0000;
      else case (op)
        3'd4: r = s32a / s32b;
        3'd5: r = ua / ub;
        3'd6: r = s32a % s32b;
        default: r = ua % ub;
      endcase
      return {{32{r[31]}}, r};
    end
    case (op)
      3'd0: return a * b;
      3'd1: begin sp = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); return sp[127:64]; end
      3'd2: begin sp = $signed({{64{a[63]}}, a}) * $signed({64'b0, b}); return sp[127:64]; end
      3'd3: begin up = {64'b0, a} * {64'b0, b}; return up[127:64]; end
      default: begin
        if (b == 0) return op[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        if (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
          return op[1] ? 64'h0 : 64'h8000_0000_0000_0000;
        case (op)
          3'd4: return sa / sb;
          3'd5: return a / b;
          3'd6: return sa % sb;
          default: return a % b;
        endcase
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    logic zero, ovf;
    zero = w ? b[31:0] == 32'h0 : b == 64'h0;
    ovf = !op[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                       : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
    if (op[2] && (zero || ovf)) return 1;
    return w ? 32 : 64;
  endfunction

  // Called one time unit after a clock edge with the unit idle; stops once out_valid is seen
  task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] tag, output logic [63:0] res, output logic [4:0] otag, output int lat);
    in_op = op; in_w = w; in_src1 = a; in_src2 = b; in_tag = tag; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1 lat++;
    end
    res = out_res; otag = out_tag;
    if (!out_valid) lat = -1;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_w = 1'b0; out_ready = 1'b0;
    in_op = 3'd0; in_src1 = '0; in_src2 = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    n_checks++; if (out_res !== 64'h0) begin n_fail++; $display("FAIL reset out_res got %h want 0", out_res); end
    n_checks++; if (out_tag !== 5'h0) begin n_fail++; $display("FAIL reset out_tag got %h want 0", out_tag); end
  endtask

  task automatic test_directed();
    logic [2:0]  ops  [7] = '{3'd1, 3'd4, 3'd6, 3'd5, 3'd7, 3'd6, 3'd0};
    logic        ws   [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [63:0] as   [7] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                              64'h1_0000_0007, 64'h1_0000_0007, 64'hFFFF_FFFF_FFFF_FFF9, 64'h7FFF_FFFF};
    logic [63:0] bs   [7] = '{64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'd2, 64'd2};
    logic [63:0] exps [7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h0,
                              64'hFFFF_FFFF_FFFF_FFFF, 64'h7, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
    int          lats [7] = '{64, 1, 1, 1, 1, 32, 32};
    logic [63:0] res;
    logic [4:0]  otag;
    int          lat;
    for (int i = 0; i < 7; i++) begin
      issue(ops[i], ws[i], as[i], bs[i], 5'(i + 9), res, otag, lat);
      n_checks++; if (res !== exps[i]) begin n_fail++; $display("FAIL directed%0d res got %h want %h", i, res, exps[i]); end
      n_checks++; if (lat !== lats[i]) begin n_fail++; $display("FAIL directed%0d latency got %0d want %0d", i, lat, lats[i]); end
      n_checks++; if (otag !== 5'(i + 9)) begin n_fail++; $display("FAIL directed%0d tag got %0d want %0d", i, otag, i + 9); end
      retire();
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic        w;
    logic [63:0] a, b, res, exp;
    logic [4:0]  tag, otag;
    int          lat, sel;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7)); w = 1'($urandom_range(0, 1)); tag = 5'($urandom);
      sel = $urandom_range(0, 7);
      a = sel == 0 ? (w ? 64'h8000_0000 : 64'h8000_0000_0000_0000) : sel == 1 ? 64'($urandom_range(0, 50)) : {$urandom, $urandom};
      sel = $urandom_range(0, 7);
      b = sel == 0 ? 64'h0 : sel == 1 ? 64'hFFFF_FFFF_FFFF_FFFF : sel == 2 ? 64'($urandom_range(1, 20)) : {$urandom, $urandom};
      exp = ref_res(op, w, a, b);
      issue(op, w, a, b, tag, res, otag, lat);
      n_checks++; if (res !== exp) begin n_fail++; $display("FAIL random%0d op%0d w%0d a=%h b=%h res got %h want %h", i, op, w, a, b, res, exp); end
      n_checks++; if (lat !== ref_lat(op, w, a, b)) begin n_fail++; $display("FAIL random%0d latency got %0d want %0d", i, lat, ref_lat(op, w, a, b)); end
      n_checks++; if (otag !== tag) begin n_fail++; $display("FAIL random%0d tag got %h want %h", i, otag, tag); end
      retire();
    end
  endtask

  task automatic test_hold_back_to_back();
    logic [63:0] res;
    logic [4:0]  otag;
    int          lat, bad;
    issue(3'd5, 1'b0, 64'd1000, 64'd3, 5'd3, res, otag, lat);
    n_checks++; if (res !== 64'd333) begin n_fail++; $display("FAIL hold res got %0d want 333", res); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_res !== 64'd333 || in_ready !== 1'b0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL hold stable got %0d bad cycles want 0", bad); end
    retire();
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL hold release in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
    issue(3'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd21, res, otag, lat);
    n_checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFA || lat !== 32) begin n_fail++; $display("FAIL back_to_back res got %h lat %0d want fffffffffffffffa 32", res, lat); end
    retire();
  endtask

  task automatic test_flush_reset();
    logic [63:0] res;
    logic [4:0]  otag;
    int          lat, seen;
    in_op = 3'd4; in_w = 1'b0; in_src1 = 64'd12345; in_src2 = 64'd7; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_vs_valid in_ready got %b want 1", in_ready); end
    flush = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
    seen = 0;
    for (int i = 0; i < 80; i++) begin @(posedge clk); #1 if (out_valid) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL flush out_valid seen %0d want 0", seen); end
    in_op = 3'd5; in_src1 = 64'd999; in_src2 = 64'd4; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_res !== 64'h0) begin n_fail++; $display("FAIL rst_busy in_ready=%b out_valid=%b out_res=%h want 1 0 0", in_ready, out_valid, out_res); end
    seen = 0;
    for (int i = 0; i < 80; i++) begin @(posedge clk); #1 if (out_valid) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rst_busy out_valid seen %0d want 0", seen); end
    issue(3'd5, 1'b0, 64'd100, 64'd7, 5'd30, res, otag, lat);
    n_checks++; if (res !== 64'd14 || otag !== 5'd30) begin n_fail++; $display("FAIL after_kill res got %0d tag %0d want 14 30", res, otag); end
    retire();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold_back_to_back();
    test_flush_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
